// File: rtl/upload_cache_addr_unit.sv
// Frame-uploader datapath helper: a 16-bit-write / 32-bit-read burst cache
// alongside an independent registered next-burst address adder.
module upload_cache_addr_unit #(
  parameter int WR_DEPTH  = 16,
  parameter int WR_WIDTH  = 16,
  parameter int READ_MODE = 0,
  parameter int A_WIDTH   = 21,
  parameter int B_WIDTH   = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cache_we,
  input  logic [$clog2(WR_DEPTH)-1:0]     cache_wr_addr,
  input  logic [WR_WIDTH-1:0]             cache_wr_data,
  input  logic                            cache_rd_en,
  input  logic                            cache_oce,
  input  logic [$clog2(WR_DEPTH/2)-1:0]   cache_rd_addr,
  output logic [2*WR_WIDTH-1:0]           cache_rd_data,
  input  logic                            addr_ce,
  input  logic [A_WIDTH-1:0]              addr_a,
  input  logic [B_WIDTH-1:0]              addr_b,
  output logic [A_WIDTH:0]                addr_sum,
  output logic [54:0]                     addr_caso
);

  localparam int SUM_W = A_WIDTH + 1;

  logic [WR_WIDTH-1:0]   mem [WR_DEPTH];
  logic [2*WR_WIDTH-1:0] rd_word;
  logic [2*WR_WIDTH-1:0] stage1;
  logic [2*WR_WIDTH-1:0] out_src;
  logic                  out_load;
  logic [SUM_W-1:0]      a_ext;
  logic [SUM_W-1:0]      b_ext;

  // The array is never reset; stale pixels surviving a reset are harmless.
  always_ff @(posedge clk) begin
    if (cache_we) begin
      mem[cache_wr_addr] <= cache_wr_data;
    end
  end

  // Even entry forms the low half, so pixels stay in arrival order.
  assign rd_word = {mem[{cache_rd_addr, 1'b1}], mem[{cache_rd_addr, 1'b0}]};

  always_ff @(posedge clk) begin
    if (reset) begin
      stage1 <= '0;
    end else if (cache_rd_en) begin
      stage1 <= rd_word;
    end
  end

  // Bypass mode reads straight into the output register; pipeline mode
  // adds stage1 in front of it and hands the output load to cache_oce.
  assign out_src  = (READ_MODE == 1) ? stage1 : rd_word;
  assign out_load = (READ_MODE == 1) ? cache_oce : cache_rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_rd_data <= '0;
    end else if (out_load) begin
      cache_rd_data <= out_src;
    end
  end

  assign a_ext = {1'b0, addr_a};
  assign b_ext = {{(SUM_W - B_WIDTH){1'b0}}, addr_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_sum <= '0;
    end else if (addr_ce) begin
      addr_sum <= a_ext + b_ext;
    end
  end

  assign addr_caso = {{(55 - SUM_W){1'b0}}, addr_sum};

endmodule

// File: tb/tb_upload_cache_addr_unit.sv
// Scoreboard bench driving a bypass-mode and a pipeline-mode instance
// with the same stimulus and checking each against bench-side expectations.
module tb_upload_cache_addr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cache_we;
  logic [3:0]  cache_wr_addr;
  logic [15:0] cache_wr_data;
  logic        cache_rd_en;
  logic        cache_oce;
  logic [2:0]  cache_rd_addr;
  logic [31:0] rd_data_b, rd_data_p;
  logic        addr_ce;
  logic [20:0] addr_a;
  logic [4:0]  addr_b;
  logic [21:0] sum_b, sum_p;
  logic [54:0] caso_b, caso_p;

  int tests = 0;
  int fails = 0;

  logic [15:0] model_mem [16];
  logic [31:0] q_b [$];
  logic [31:0] q_p [$];
  logic [21:0] q_sum [$];

  always #5 clk = ~clk;

  upload_cache_addr_unit #(.READ_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .cache_we(cache_we), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_rd_en(cache_rd_en), .cache_oce(cache_oce),
    .cache_rd_addr(cache_rd_addr), .cache_rd_data(rd_data_b), .addr_ce(addr_ce),
    .addr_a(addr_a), .addr_b(addr_b), .addr_sum(sum_b), .addr_caso(caso_b)
  );

  upload_cache_addr_unit #(.READ_MODE(1)) dut_p (
    .clk(clk), .reset(reset), .cache_we(cache_we), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_rd_en(cache_rd_en), .cache_oce(cache_oce),
    .cache_rd_addr(cache_rd_addr), .cache_rd_data(rd_data_p), .addr_ce(addr_ce),
    .addr_a(addr_a), .addr_b(addr_b), .addr_sum(sum_p), .addr_caso(caso_p)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int k);
    return {model_mem[2*k+1], model_mem[2*k]};
  endfunction

  task automatic idle_inputs();
    cache_we = 1'b0; cache_wr_addr = '0; cache_wr_data = '0;
    cache_rd_en = 1'b0; cache_oce = 1'b0; cache_rd_addr = '0;
    addr_ce = 1'b0; addr_a = '0; addr_b = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cache_we = 1'b1; cache_rd_en = 1'b1; cache_oce = 1'b1; addr_ce = 1'b1;
    addr_a = 21'h1ABCDE; addr_b = 5'd7;
    tick(); tick();
    tests++;
    if (rd_data_b !== 32'h0) begin fails++; $display("[TB] FAIL reset_rd_b: got %h expected %h", rd_data_b, 32'h0); end
    tests++;
    if (rd_data_p !== 32'h0) begin fails++; $display("[TB] FAIL reset_rd_p: got %h expected %h", rd_data_p, 32'h0); end
    tests++;
    if (sum_b !== 22'h0 || sum_p !== 22'h0) begin fails++; $display("[TB] FAIL reset_sum: got %h/%h expected 0", sum_b, sum_p); end
    tests++;
    if (caso_b !== 55'h0) begin fails++; $display("[TB] FAIL reset_caso: got %h expected 0", caso_b); end
    reset = 1'b0;
    cache_we = 1'b0;
    addr_a = 21'h5; addr_b = 5'd3;
    q_sum.push_back(22'h8);
    tick();
    tests++;
    if (sum_b !== q_sum[0]) begin fails++; $display("[TB] FAIL release_sum: got %h expected %h", sum_b, q_sum[0]); end
    void'(q_sum.pop_front());
    tests++;
    if (rd_data_p !== 32'h0) begin fails++; $display("[TB] FAIL release_pipe_stage: got %h expected 0", rd_data_p); end
    idle_inputs();
  endtask

  task automatic test_pack();
    logic [31:0] exp;
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      cache_we = 1'b1; cache_wr_addr = 4'(i); cache_wr_data = 16'h1000 + 16'(i);
      model_mem[i] = 16'h1000 + 16'(i);
      tick();
    end
    cache_we = 1'b0;
    cache_oce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cache_rd_en = 1'b1; cache_rd_addr = 3'(k);
      q_b.push_back(model_word(k));
      q_p.push_back(model_word(k));
      tick();
      exp = q_b.pop_front();
      tests++;
      if (rd_data_b !== exp) begin fails++; $display("[TB] FAIL pack_byp k=%0d: got %h expected %h", k, rd_data_b, exp); end
      if (k == 3) begin
        tests++;
        if (rd_data_b !== 32'h10071006) begin fails++; $display("[TB] FAIL pack_k3: got %h expected %h", rd_data_b, 32'h10071006); end
      end
      if (k >= 1) begin
        exp = q_p.pop_front();
        tests++;
        if (rd_data_p !== exp) begin fails++; $display("[TB] FAIL pack_pipe k=%0d: got %h expected %h", k - 1, rd_data_p, exp); end
      end
    end
    cache_rd_en = 1'b0;
    tick();
    exp = q_p.pop_front();
    tests++;
    if (rd_data_p !== exp) begin fails++; $display("[TB] FAIL pack_pipe k=7: got %h expected %h", rd_data_p, exp); end
    idle_inputs();
  endtask

  task automatic test_hold();
    idle_inputs();
    cache_rd_en = 1'b1; cache_rd_addr = 3'd2; cache_oce = 1'b1;
    tick(); tick();
    cache_rd_en = 1'b0; cache_rd_addr = 3'd5;
    tick();
    tests++;
    if (rd_data_b !== 32'h10051004) begin fails++; $display("[TB] FAIL hold_byp: got %h expected %h", rd_data_b, 32'h10051004); end
    tests++;
    if (rd_data_p !== 32'h10051004) begin fails++; $display("[TB] FAIL hold_pipe: got %h expected %h", rd_data_p, 32'h10051004); end
    cache_oce = 1'b0; cache_rd_en = 1'b1; cache_rd_addr = 3'd6;
    tick();
    cache_rd_en = 1'b0;
    tick();
    tests++;
    if (rd_data_b !== 32'h100D100C) begin fails++; $display("[TB] FAIL byp_ignores_oce: got %h expected %h", rd_data_b, 32'h100D100C); end
    tests++;
    if (rd_data_p !== 32'h10051004) begin fails++; $display("[TB] FAIL pipe_oce_freeze: got %h expected %h", rd_data_p, 32'h10051004); end
    cache_oce = 1'b1;
    tick();
    tests++;
    if (rd_data_p !== 32'h100D100C) begin fails++; $display("[TB] FAIL pipe_oce_load: got %h expected %h", rd_data_p, 32'h100D100C); end
    idle_inputs();
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp;
    idle_inputs();
    cache_we = 1'b1; cache_wr_addr = 4'd4; cache_wr_data = 16'hAAAA;
    model_mem[4] = 16'hAAAA;
    tick();
    cache_wr_data = 16'hBBBB; cache_rd_en = 1'b1; cache_rd_addr = 3'd2; cache_oce = 1'b1;
    q_b.push_back(model_word(2));
    model_mem[4] = 16'hBBBB;
    tick();
    exp = q_b.pop_front();
    tests++;
    if (rd_data_b !== exp || rd_data_b[15:0] !== 16'hAAAA) begin fails++; $display("[TB] FAIL rdw_old: got %h expected %h", rd_data_b, exp); end
    cache_we = 1'b0;
    q_b.push_back(model_word(2));
    tick();
    exp = q_b.pop_front();
    tests++;
    if (rd_data_b !== exp) begin fails++; $display("[TB] FAIL rdw_new: got %h expected %h", rd_data_b, exp); end
    tests++;
    if (rd_data_p !== 32'h1005AAAA) begin fails++; $display("[TB] FAIL rdw_pipe_old: got %h expected %h", rd_data_p, 32'h1005AAAA); end
    cache_rd_en = 1'b0;
    tick();
    tests++;
    if (rd_data_p !== 32'h1005BBBB) begin fails++; $display("[TB] FAIL rdw_pipe_new: got %h expected %h", rd_data_p, 32'h1005BBBB); end
    idle_inputs();
  endtask

  task automatic test_adder();
    logic [21:0] exp;
    idle_inputs();
    addr_ce = 1'b1; addr_a = 21'h000100; addr_b = 5'd16;
    q_sum.push_back(22'h000110);
    tick();
    exp = q_sum.pop_front();
    tests++;
    if (sum_b !== exp || sum_p !== exp) begin fails++; $display("[TB] FAIL add_basic: got %h/%h expected %h", sum_b, sum_p, exp); end
    addr_a = 21'h1FFFFF; addr_b = 5'd31;
    q_sum.push_back(22'h20001E);
    tick();
    exp = q_sum.pop_front();
    tests++;
    if (sum_b !== exp) begin fails++; $display("[TB] FAIL add_max: got %h expected %h", sum_b, exp); end
    tests++;
    if (caso_b !== 55'h20001E || caso_p !== 55'h20001E) begin fails++; $display("[TB] FAIL add_caso: got %h expected %h", caso_b, 55'h20001E); end
    addr_ce = 1'b0; addr_a = '0; addr_b = '0;
    tick();
    tests++;
    if (sum_b !== 22'h20001E) begin fails++; $display("[TB] FAIL add_hold: got %h expected %h", sum_b, 22'h20001E); end
    addr_ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr_a = 21'($urandom); addr_b = 5'($urandom);
      q_sum.push_back({1'b0, addr_a} + {17'b0, addr_b});
      tick();
      exp = q_sum.pop_front();
      tests++;
      if (sum_b !== exp || caso_b !== {33'b0, exp}) begin fails++; $display("[TB] FAIL add_rand %0d: got %h expected %h", i, sum_b, exp); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    logic [21:0] exp_s;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      cache_we = 1'b1; cache_wr_addr = 4'(8 + i); cache_wr_data = 16'(16'hC000 + i * 3);
      cache_rd_en = 1'b1; cache_rd_addr = 3'(i);
      addr_ce = 1'b1; addr_a = 21'(i * 21'h10000); addr_b = 5'(i + 9);
      q_b.push_back(model_word(i));
      q_sum.push_back({1'b0, addr_a} + {17'b0, addr_b});
      model_mem[8 + i] = cache_wr_data;
      tick();
      exp_w = q_b.pop_front();
      exp_s = q_sum.pop_front();
      tests++;
      if (rd_data_b !== exp_w || sum_b !== exp_s) begin
        fails++;
        $display("[TB] FAIL b2b %0d: got %h/%h expected %h/%h", i, rd_data_b, sum_b, exp_w, exp_s);
      end
    end
    cache_we = 1'b0; addr_ce = 1'b0;
    cache_rd_addr = 3'd4;
    q_b.push_back(model_word(4));
    tick();
    exp_w = q_b.pop_front();
    tests++;
    if (rd_data_b !== exp_w) begin fails++; $display("[TB] FAIL b2b_readback: got %h expected %h", rd_data_b, exp_w); end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    logic [31:0] exp;
    idle_inputs();
    cache_rd_en = 1'b1; cache_rd_addr = 3'd1; cache_oce = 1'b1;
    addr_ce = 1'b1; addr_a = 21'h1234; addr_b = 5'd1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (rd_data_b !== 32'h0 || rd_data_p !== 32'h0) begin fails++; $display("[TB] FAIL midrst_rd: got %h/%h expected 0", rd_data_b, rd_data_p); end
    tests++;
    if (sum_b !== 22'h0 || caso_b !== 55'h0) begin fails++; $display("[TB] FAIL midrst_sum: got %h/%h expected 0", sum_b, caso_b); end
    q_b.push_back(model_word(1));
    tick();
    exp = q_b.pop_front();
    tests++;
    if (rd_data_b !== exp || rd_data_b !== 32'h10031002) begin fails++; $display("[TB] FAIL midrst_mem: got %h expected %h", rd_data_b, exp); end
    tests++;
    if (sum_b !== 22'h1235) begin fails++; $display("[TB] FAIL midrst_sum_resume: got %h expected %h", sum_b, 22'h1235); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_pack();
    test_hold();
    test_read_during_write();
    test_adder();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/upload_cache_addr_unit.md
Name: upload_cache_addr_unit

Overview:
- Datapath helper for the frame uploader, which moves pixels from the camera queue to external memory in bursts.
- Two independent sub-blocks share one clock and reset:
  - A semi-dual-port burst cache: 16-bit pixel writes, 32-bit word reads.
  - A registered address adder: next burst address = current address + pixels written.
- Replaces the vendor SDPB cache and ALU54 adder primitives with portable RTL of identical cycle behaviour.

Parameters:
- WR_DEPTH, 16, number of 16-bit cache entries; must be even. Read depth is WR_DEPTH/2.
- WR_WIDTH, 16, write data width. Read width is 2*WR_WIDTH.
- READ_MODE, 0, 0 = bypass (1-cycle read latency); 1 = pipeline (extra output register gated by cache_oce).
- A_WIDTH, 21, adder operand A width.
- B_WIDTH, 5, adder operand B width; must be <= A_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- cache_we  in  1  write enable (port A).
- cache_wr_addr  in  log2(WR_DEPTH)=4  write entry index.
- cache_wr_data  in  WR_WIDTH=16  pixel data.
- cache_rd_en  in  1  read clock enable (port B).
- cache_oce  in  1  output-register enable; used only when READ_MODE=1.
- cache_rd_addr  in  log2(WR_DEPTH/2)=3  read word index.
- cache_rd_data  out  2*WR_WIDTH=32  read word.
- addr_ce  in  1  adder clock enable.
- addr_a  in  A_WIDTH=21  base address.
- addr_b  in  B_WIDTH=5  increment, unsigned.
- addr_sum  out  A_WIDTH+1=22  registered sum.
- addr_caso  out  55  cascade output.

Behaviour:
- Reset (synchronous, on rising clk with reset=1):
  - cache_rd_data=0, the pipeline register=0, addr_sum=0, addr_caso=0.
  - Memory array contents are not cleared.
  - Reset has priority over all enables.
- Cache write:
  - On a rising edge with cache_we=1, mem[cache_wr_addr] <= cache_wr_data.
  - With cache_we=0, memory holds.
- Cache read packing: word k = {mem[2k+1], mem[2k]}. The even entry is the low half (little-endian pixel order).
- READ_MODE=0:
  - On a rising edge with cache_rd_en=1, cache_rd_data <= word[cache_rd_addr] (1-cycle latency).
  - cache_rd_en=0 holds cache_rd_data.
  - cache_oce is ignored.
- READ_MODE=1:
  - Stage 1 register loads when cache_rd_en=1.
  - cache_rd_data loads from stage 1 when cache_oce=1 (2-cycle latency).
- Simultaneous write and read of an overlapping entry in the same cycle: the read returns the old (pre-write) data, i.e. read-before-write.
- Out-of-range addresses cannot occur, since address widths exactly cover the depth.
- Adder:
  - On a rising edge with addr_ce=1, addr_sum <= zero_extend(addr_a) + zero_extend(addr_b).
  - Unsigned, full A_WIDTH+1 result with no truncation. Maximum 0x1FFFFF+31 = 0x20001E fits.
  - addr_ce=0 holds addr_sum.
  - Latency is 1 cycle; no combinational path from inputs to outputs.
- addr_caso = zero_extend_55(addr_sum), updated in the same cycle as addr_sum.
- The cache and adder are fully independent; any combination of enables in the same cycle is legal.
- Reset asserted mid-burst:
  - Outputs go to 0 on that edge.
  - Subsequent writes and reads work normally.
  - Stale memory data may remain.

Test Plan:
- Reset then idle: assert reset 2 cycles with all enables high -> cache_rd_data=0, addr_sum=0, addr_caso=0. Release -> outputs update on the next enabled edge.
- Pack order: write entries 0..15 with 0x1000+i. Read addr 0..7 with cache_rd_en=1 -> the cycle after addr k, cache_rd_data={0x1000+2k+1, 0x1000+2k}, e.g. k=3 gives 0x10071006.
- Hold: after reading word 2, drop cache_rd_en and change cache_rd_addr -> cache_rd_data stays 0x10051004. Set READ_MODE=1 with cache_oce=0 -> output frozen; cache_oce=1 -> updates one cycle after stage 1.
- Read-during-write: entry 4 holds 0xAAAA; same cycle write 0xBBBB to entry 4 and read word 2 -> low half 0xAAAA. The next read gives 0xBBBB.
- Adder: a=0x000100, b=16, ce=1 -> addr_sum=0x000110 one cycle later. a=0x1FFFFF, b=31 -> 0x20001E, caso=0x20001E. Then ce=0 with a=0 -> sum holds.
- Mid-operation reset: during a read burst and adder update, pulse reset 1 cycle -> all outputs 0 the next cycle. Written memory still reads back its previous values.
